// File: rtl/shot_resolver.sv
// Battleship shot resolver: holds the ship placement and shot history for one
// 10x10 board, accepts one shot at a time and returns a registered hit / miss /
// repeat / invalid verdict with a fixed two-cycle accept-to-response latency.
module shot_resolver #(
  parameter int MAX_SHIP_CELLS = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_game,
  input  logic       load_en,
  input  logic [6:0] load_cell,
  input  logic       load_done,
  input  logic       shot_valid,
  input  logic [6:0] shot_cell,
  output logic       shot_ready,
  output logic       resp_valid,
  output logic       resp_hit,
  output logic       resp_miss,
  output logic       resp_repeat,
  output logic       resp_invalid,
  output logic [4:0] hits_remaining,
  output logic       game_over
);

  localparam int unsigned BOARD_CELLS = 100;

  typedef enum logic [2:0] {
    S_LOAD    = 3'd0,
    S_READY   = 3'd1,
    S_LOOKUP  = 3'd2,
    S_RESPOND = 3'd3,
    S_OVER    = 3'd4
  } state_t;

  state_t                   state_q;
  logic [BOARD_CELLS-1:0]   ship_map_q;
  logic [BOARD_CELLS-1:0]   shot_map_q;
  logic [6:0]               shot_cell_q;
  logic [4:0]               hits_q;
  logic                     game_over_q;
  logic                     shot_ready_q;
  logic                     resp_valid_q;
  logic                     resp_hit_q;
  logic                     resp_miss_q;
  logic                     resp_repeat_q;
  logic                     resp_invalid_q;

  // Placement qualification and the count as it stands after a same-cycle load.
  logic                     load_in_range;
  logic [6:0]               load_idx;
  logic                     load_ok;
  logic [4:0]               hits_after_load_d;

  // Classification of the latched shot cell.
  logic                     shot_in_range;
  logic [6:0]               shot_idx;
  logic                     cls_invalid;
  logic                     cls_repeat;
  logic                     cls_hit;
  logic                     cls_miss;

  // Qualify a placement strobe and derive the post-load ship count.
  always_comb begin
    load_in_range     = (load_cell < 7'(BOARD_CELLS));
    // Out-of-range cells are steered to index 0 so the map is never read past its end.
    load_idx          = load_in_range ? load_cell : '0;
    load_ok           = load_en && load_in_range && !ship_map_q[load_idx] &&
                        (hits_q < 5'(MAX_SHIP_CELLS));
    hits_after_load_d = hits_q + {4'b0000, load_ok};
  end

  // Priority classification of the latched shot: invalid, repeat, hit, miss.
  always_comb begin
    shot_in_range = (shot_cell_q < 7'(BOARD_CELLS));
    shot_idx      = shot_in_range ? shot_cell_q : '0;
    cls_invalid   = !shot_in_range;
    cls_repeat    = shot_in_range && shot_map_q[shot_idx];
    cls_hit       = shot_in_range && !shot_map_q[shot_idx] && ship_map_q[shot_idx];
    cls_miss      = shot_in_range && !shot_map_q[shot_idx] && !ship_map_q[shot_idx];
  end

  // Resolver FSM with board state and registered outputs; new_game overrides everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_LOAD;
      ship_map_q     <= '0;
      shot_map_q     <= '0;
      shot_cell_q    <= '0;
      hits_q         <= '0;
      game_over_q    <= 1'b0;
      shot_ready_q   <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_hit_q     <= 1'b0;
      resp_miss_q    <= 1'b0;
      resp_repeat_q  <= 1'b0;
      resp_invalid_q <= 1'b0;
    end else if (new_game) begin
      state_q        <= S_LOAD;
      ship_map_q     <= '0;
      shot_map_q     <= '0;
      shot_cell_q    <= '0;
      hits_q         <= '0;
      game_over_q    <= 1'b0;
      shot_ready_q   <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_hit_q     <= 1'b0;
      resp_miss_q    <= 1'b0;
      resp_repeat_q  <= 1'b0;
      resp_invalid_q <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (load_ok) begin
            ship_map_q[load_idx] <= 1'b1;
            hits_q               <= hits_after_load_d;
          end
          // The same-cycle load is counted before deciding whether placement may end.
          if (load_done && (hits_after_load_d != '0)) begin
            state_q      <= S_READY;
            shot_ready_q <= 1'b1;
          end
        end

        S_READY: begin
          if (shot_valid) begin
            shot_cell_q  <= shot_cell;
            shot_ready_q <= 1'b0;
            state_q      <= S_LOOKUP;
          end
        end

        S_LOOKUP: begin
          resp_valid_q   <= 1'b1;
          resp_hit_q     <= cls_hit;
          resp_miss_q    <= cls_miss;
          resp_repeat_q  <= cls_repeat;
          resp_invalid_q <= cls_invalid;
          state_q        <= S_RESPOND;
        end

        S_RESPOND: begin
          resp_valid_q   <= 1'b0;
          resp_hit_q     <= 1'b0;
          resp_miss_q    <= 1'b0;
          resp_repeat_q  <= 1'b0;
          resp_invalid_q <= 1'b0;
          // The registered verdict doubles as the map-update qualifier; hit/miss imply an in-range cell.
          if (resp_hit_q || resp_miss_q) begin
            shot_map_q[shot_idx] <= 1'b1;
          end
          if (resp_hit_q && (hits_q != '0)) begin
            hits_q <= hits_q - 5'd1;
          end
          if (resp_hit_q && (hits_q <= 5'd1)) begin
            game_over_q  <= 1'b1;
            shot_ready_q <= 1'b0;
            state_q      <= S_OVER;
          end else begin
            shot_ready_q <= 1'b1;
            state_q      <= S_READY;
          end
        end

        S_OVER: begin
          game_over_q  <= 1'b1;
          shot_ready_q <= 1'b0;
        end

        default: begin
          state_q      <= S_LOAD;
          shot_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign shot_ready     = shot_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_hit       = resp_hit_q;
  assign resp_miss      = resp_miss_q;
  assign resp_repeat    = resp_repeat_q;
  assign resp_invalid   = resp_invalid_q;
  assign hits_remaining = hits_q;
  assign game_over      = game_over_q;

endmodule

// File: tb/tb_shot_resolver.sv
// Self-checking bench for shot_resolver: expected verdicts are queued when a
// shot is driven and checked by a monitor when resp_valid appears.
module tb_shot_resolver;

  localparam logic [3:0] F_HIT = 4'b1000;
  localparam logic [3:0] F_MIS = 4'b0100;
  localparam logic [3:0] F_REP = 4'b0010;
  localparam logic [3:0] F_INV = 4'b0001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       new_game = 1'b0;
  logic       load_en = 1'b0;
  logic [6:0] load_cell = '0;
  logic       load_done = 1'b0;
  logic       shot_valid = 1'b0;
  logic [6:0] shot_cell = '0;
  logic       shot_ready;
  logic       resp_valid;
  logic       resp_hit;
  logic       resp_miss;
  logic       resp_repeat;
  logic       resp_invalid;
  logic [4:0] hits_remaining;
  logic       game_over;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic [3:0] flags;
  } exp_t;
  exp_t sb[$];

  shot_resolver #(.MAX_SHIP_CELLS(17)) dut (
    .clk(clk),
    .reset(reset),
    .new_game(new_game),
    .load_en(load_en),
    .load_cell(load_cell),
    .load_done(load_done),
    .shot_valid(shot_valid),
    .shot_cell(shot_cell),
    .shot_ready(shot_ready),
    .resp_valid(resp_valid),
    .resp_hit(resp_hit),
    .resp_miss(resp_miss),
    .resp_repeat(resp_repeat),
    .resp_invalid(resp_invalid),
    .hits_remaining(hits_remaining),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Response monitor: pops the scoreboard on every response and polices idle cycles.
  always @(negedge clk) begin
    logic [3:0] flags;
    exp_t e;
    flags = {resp_hit, resp_miss, resp_repeat, resp_invalid};
    while (sb.size() != 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_resp: expected flags %b at cycle %0d, got no response", e.flags, e.cyc);
    end
    vectors++;
    if (resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_resp: got resp_valid flags %b at cycle %0d, required none", flags, cyc);
      end else begin
        e = sb.pop_front();
        if (e.cyc !== cyc || flags !== e.flags) begin
          miscompares++;
          $display("FAIL resp: got flags %b at cycle %0d, required %b at cycle %0d", flags, cyc, e.flags, e.cyc);
        end
      end
    end else if (flags !== 4'b0000 || resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_flags: got valid=%b flags %b, required 0 0000", resp_valid, flags);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_new_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
  endtask

  task automatic do_load(input logic [6:0] c);
    load_en = 1'b1;
    load_cell = c;
    tick();
    load_en = 1'b0;
  endtask

  task automatic do_done();
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
  endtask

  task automatic shoot(input logic [6:0] c, input logic [3:0] f);
    shot_valid = 1'b1;
    shot_cell = c;
    sb.push_back('{cyc: cyc + 2, flags: f});
    tick();
    shot_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    @(negedge clk);
    vectors++;
    if ({shot_ready, resp_valid, game_over, hits_remaining} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_outputs: got ready=%b valid=%b over=%b hits=%0d, required all 0",
               shot_ready, resp_valid, game_over, hits_remaining);
    end
    tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    vectors++;
    if ({shot_ready, game_over, hits_remaining} !== 7'h00) begin
      miscompares++;
      $display("FAIL post_reset: got ready=%b over=%b hits=%0d, required 0 0 0",
               shot_ready, game_over, hits_remaining);
    end
  endtask

  task automatic test_hit();
    do_new_game();
    do_load(7'd0);
    do_load(7'd1);
    do_load(7'd2);
    @(negedge clk);
    vectors++;
    if (hits_remaining !== 5'd3 || shot_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL load3: got hits=%0d ready=%b, required 3 0", hits_remaining, shot_ready);
    end
    tick();
    do_done();
    @(negedge clk);
    vectors++;
    if (shot_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_done: got %b, required 1", shot_ready);
    end
    tick();
    shot_valid = 1'b1;
    shot_cell = 7'd1;
    sb.push_back('{cyc: cyc + 2, flags: F_HIT});
    tick();
    // This second request arrives while busy and must be dropped.
    shot_cell = 7'd2;
    @(negedge clk);
    vectors++;
    if (shot_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_in_lookup: got %b, required 0", shot_ready);
    end
    tick();
    shot_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (shot_ready !== 1'b0 || hits_remaining !== 5'd3) begin
      miscompares++;
      $display("FAIL respond_cycle: got ready=%b hits=%0d, required 0 3", shot_ready, hits_remaining);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (shot_ready !== 1'b1 || hits_remaining !== 5'd2) begin
      miscompares++;
      $display("FAIL after_hit: got ready=%b hits=%0d, required 1 2", shot_ready, hits_remaining);
    end
  endtask

  task automatic test_miss_repeat();
    shoot(7'd55, F_MIS);
    @(negedge clk);
    vectors++;
    if (hits_remaining !== 5'd2) begin
      miscompares++;
      $display("FAIL miss_hits: got %0d, required 2", hits_remaining);
    end
    shoot(7'd55, F_REP);
    shoot(7'd1, F_REP);
    @(negedge clk);
    vectors++;
    if (hits_remaining !== 5'd2 || shot_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL repeat_hits: got hits=%0d ready=%b, required 2 1", hits_remaining, shot_ready);
    end
  endtask

  task automatic test_invalid();
    shoot(7'd120, F_INV);
    shoot(7'd100, F_INV);
    shoot(7'd99, F_MIS);
    // Load strobes outside placement are ignored.
    do_load(7'd44);
    @(negedge clk);
    vectors++;
    if (hits_remaining !== 5'd2) begin
      miscompares++;
      $display("FAIL invalid_hits: got %0d, required 2", hits_remaining);
    end
    shoot(7'd44, F_MIS);
  endtask

  task automatic test_game_over();
    shoot(7'd0, F_HIT);
    @(negedge clk);
    vectors++;
    if (hits_remaining !== 5'd1 || game_over !== 1'b0) begin
      miscompares++;
      $display("FAIL one_left: got hits=%0d over=%b, required 1 0", hits_remaining, game_over);
    end
    shoot(7'd2, F_HIT);
    @(negedge clk);
    vectors++;
    if (hits_remaining !== 5'd0 || game_over !== 1'b1 || shot_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL game_over: got hits=%0d over=%b ready=%b, required 0 1 0",
               hits_remaining, game_over, shot_ready);
    end
    shot_valid = 1'b1;
    shot_cell = 7'd5;
    load_en = 1'b1;
    load_cell = 7'd9;
    load_done = 1'b1;
    repeat (5) tick();
    shot_valid = 1'b0;
    load_en = 1'b0;
    load_done = 1'b0;
    @(negedge clk);
    vectors++;
    if (hits_remaining !== 5'd0 || game_over !== 1'b1 || shot_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL over_hold: got hits=%0d over=%b ready=%b, required 0 1 0",
               hits_remaining, game_over, shot_ready);
    end
  endtask

  task automatic test_load_rules();
    do_new_game();
    @(negedge clk);
    vectors++;
    if (game_over !== 1'b0 || hits_remaining !== 5'd0) begin
      miscompares++;
      $display("FAIL new_game_clear: got over=%b hits=%0d, required 0 0", game_over, hits_remaining);
    end
    do_done();
    tick();
    @(negedge clk);
    vectors++;
    if (shot_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_done: got ready=%b, required 0", shot_ready);
    end
    do_load(7'd4);
    do_load(7'd4);
    do_load(7'd100);
    do_load(7'd127);
    @(negedge clk);
    vectors++;
    if (hits_remaining !== 5'd1) begin
      miscompares++;
      $display("FAIL dup_range: got hits=%0d, required 1", hits_remaining);
    end
    load_en = 1'b1;
    load_cell = 7'd7;
    load_done = 1'b1;
    tick();
    load_en = 1'b0;
    load_done = 1'b0;
    @(negedge clk);
    vectors++;
    if (hits_remaining !== 5'd2 || shot_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL load_with_done: got hits=%0d ready=%b, required 2 1", hits_remaining, shot_ready);
    end
    tick();
    shoot(7'd7, F_HIT);
  endtask

  task automatic test_saturation();
    do_new_game();
    for (int unsigned i = 0; i < 18; i++) begin
      do_load(7'(10 + i));
    end
    @(negedge clk);
    vectors++;
    if (hits_remaining !== 5'd17) begin
      miscompares++;
      $display("FAIL saturate: got hits=%0d, required 17", hits_remaining);
    end
    tick();
    do_done();
    shoot(7'd27, F_MIS);
    shoot(7'd26, F_HIT);
    @(negedge clk);
    vectors++;
    if (hits_remaining !== 5'd16) begin
      miscompares++;
      $display("FAIL sat_hit: got hits=%0d, required 16", hits_remaining);
    end
  endtask

  task automatic test_new_game_abort();
    tick();
    shot_valid = 1'b1;
    shot_cell = 7'd10;
    tick();
    shot_valid = 1'b0;
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    @(negedge clk);
    vectors++;
    if (hits_remaining !== 5'd0 || shot_ready !== 1'b0 || game_over !== 1'b0) begin
      miscompares++;
      $display("FAIL ng_abort: got hits=%0d ready=%b over=%b, required 0 0 0",
               hits_remaining, shot_ready, game_over);
    end
    tick();
    do_load(7'd26);
    do_load(7'd30);
    do_done();
    shoot(7'd11, F_MIS);
    shoot(7'd26, F_HIT);
    @(negedge clk);
    vectors++;
    if (hits_remaining !== 5'd1) begin
      miscompares++;
      $display("FAIL ng_board: got hits=%0d, required 1", hits_remaining);
    end
  endtask

  task automatic test_reset_abort();
    tick();
    shot_valid = 1'b1;
    shot_cell = 7'd30;
    tick();
    shot_valid = 1'b0;
    reset = 1'b1;
    #1;
    vectors++;
    if (hits_remaining !== 5'd0 || shot_ready !== 1'b0 || resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_abort: got hits=%0d ready=%b valid=%b, required 0 0 0",
               hits_remaining, shot_ready, resp_valid);
    end
    tick();
    tick();
    reset = 1'b0;
    tick();
    do_load(7'd26);
    do_done();
    shoot(7'd26, F_HIT);
    @(negedge clk);
    vectors++;
    if (hits_remaining !== 5'd0 || game_over !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_board: got hits=%0d over=%b, required 0 1", hits_remaining, game_over);
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_miss_repeat();
    test_invalid();
    test_game_over();
    test_load_rules();
    test_saturation();
    test_new_game_abort();
    test_reset_abort();
    repeat (4) tick();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
